// File: rtl/anode_scan_ctrl.sv
// anode_scan_ctrl: time-multiplexed display anode scanner with guarded slots and a
// double-buffered frame. Define LEADING_ZERO_BLANK_EN to blank leading-zero digits.
module anode_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int GUARD  = 2,
    parameter int DWELL  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                upd_valid,
    input  logic [4*DIGITS-1:0] upd_data,
    output logic                upd_ready,
    output logic [DIGITS-1:0]   an,
    output logic [3:0]          char,
    output logic                frame_done
);
    localparam int SLOT = GUARD + DWELL;
    localparam int CW   = $clog2(SLOT);
    localparam int DW   = $clog2(DIGITS);
    localparam logic [CW-1:0] C_ON   = CW'(GUARD);
    localparam logic [CW-1:0] C_LAST = CW'(SLOT - 1);
    localparam logic [DW-1:0] D_TOP  = DW'(DIGITS - 1);

    // IDLE covers both reset and en=0: the position is parked at c=0 of a slot.
    typedef enum logic {IDLE, SCAN} state_t;

    state_t                 state, state_nx;
    logic [DW-1:0]          dig, dig_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic [DIGITS-1:0][3:0] active, active_nx, pending;
    logic                   pend_full, pend_full_nx;
    logic                   accept, boundary, blank;
    logic [DIGITS-1:0]      an_nx;
    logic [3:0]             char_nx;
    logic                   frame_done_nx;

    assign upd_ready = !pend_full;
    assign accept    = upd_valid && !pend_full;

    // NOTE: non-blocking assignments make every flop update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dig        <= D_TOP;
            cnt        <= '0;
            // NOTE: the frame buffers are reset as well, so a reset always discards stale data.
            active     <= '0;
            pending    <= '0;
            pend_full  <= 1'b0;
            an         <= '1;
            char       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            dig        <= dig_nx;
            cnt        <= cnt_nx;
            active     <= active_nx;
            pend_full  <= pend_full_nx;
            if (accept) pending <= upd_data;
            an         <= an_nx;
            char       <= char_nx;
            frame_done <= frame_done_nx;
        end
    end

    // NOTE: every always_comb assigns its outputs a default first, so no latch is inferred.
    always_comb begin
        state_nx = state;
        dig_nx   = dig;
        cnt_nx   = cnt;
        if (!en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (state == IDLE) begin
            state_nx = SCAN;
            cnt_nx   = '0;
        end else if (cnt == C_LAST) begin
            cnt_nx = '0;
            dig_nx = (dig == '0) ? D_TOP : dig - 1'b1;
        end else begin
            cnt_nx = cnt + 1'b1;
        end
    end

    // The frame boundary is the edge that enters c=0 of the top digit while scanning.
    assign boundary = (state_nx == SCAN) && (cnt_nx == '0) && (dig_nx == D_TOP);

    always_comb begin
        active_nx    = active;
        pend_full_nx = pend_full;
        if (boundary && pend_full) begin
            active_nx    = pending;
            pend_full_nx = 1'b0;
        end else if (accept) begin
            pend_full_nx = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit blanks when it and every higher nibble are zero; digit 0 always lights.
    always_comb begin
        blank = (dig_nx != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(dig_nx) && active_nx[i] != 4'd0) blank = 1'b0;
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Outputs are computed from the next position and registered alongside it.
    always_comb begin
        an_nx         = '1;
        char_nx       = char;
        frame_done_nx = 1'b0;
        if (state_nx == SCAN) begin
            if (cnt_nx == '0) char_nx = active_nx[dig_nx];
            if (cnt_nx >= C_ON && !blank) an_nx[dig_nx] = 1'b0;
            frame_done_nx = (dig_nx == '0) && (cnt_nx == C_LAST);
        end
    end

endmodule
